// File: rtl/dna_pkg.sv
// Shared constants, state encoding and helpers for the DNA port responder.
package dna_pkg;

    localparam int DNA_WIDTH = 57;
    localparam int CNT_W     = 6;

    localparam logic [DNA_WIDTH-1:0] DNA_DEFAULT_ID = 57'h123456789ABCDEF;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_LOADED   = 2'd1,
        ST_SHIFTING = 2'd2,
        ST_DONE     = 2'd3
    } dna_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer with a rising-edge detector that only arms once
// the synchronized input has been seen low after reset.
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic pre
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_rise_det: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync;
    logic              prev;
    logic              armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-2:0], d};
            prev  <= sync[STAGES-1];
            // A high level straight out of reset must not look like a rise.
            if (!sync[STAGES-1])
                armed <= 1'b1;
        end
    end

    assign level = sync[STAGES-1];
    assign pre   = prev;
    assign rise  = armed & sync[STAGES-1] & ~prev;

endmodule

// File: rtl/dna_port_responder.sv
// Device-ID serial responder: oversamples the initiator's dna_clk and
// behaves like a DNA primitive (load on READ, MSB-first shift-out).
module dna_port_responder
    import dna_pkg::*;
#(
    parameter int                  ID_WIDTH    = DNA_WIDTH,
    parameter logic [ID_WIDTH-1:0] ID_VALUE    = ID_WIDTH'(DNA_DEFAULT_ID),
    parameter int                  SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dna_clk,
    input  logic             dna_read,
    input  logic             dna_shift,
    input  logic             dna_din,
    output logic             dna_dout,
    output logic             loaded,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done,
    output logic             shift_err
);

    if (ID_WIDTH < 2 || ID_WIDTH > 63) begin : g_bad_width
        $error("dna_port_responder: ID_WIDTH must be in 2..63");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("dna_port_responder: SYNC_STAGES must be at least 2");
    end

    localparam logic [CNT_W-1:0] ID_CNT = CNT_W'(ID_WIDTH);

    logic clk_level, clk_rise, clk_pre;

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_clk_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dna_clk),
        .level (clk_level),
        .rise  (clk_rise),
        .pre   (clk_pre)
    );

    logic unused_clk_levels;
    assign unused_clk_levels = &{1'b0, clk_level, clk_pre};

    // Controls ride a chain of the same depth plus one, so at the rise they
    // show the value from the cycle before the edge, as a primitive would.
    logic [SYNC_STAGES-1:0][2:0] ctl_sync;
    logic [2:0]                  ctl_pre;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_sync <= '0;
            ctl_pre  <= '0;
        end else begin
            ctl_sync <= {ctl_sync[SYNC_STAGES-2:0], {dna_read, dna_shift, dna_din}};
            ctl_pre  <= ctl_sync[SYNC_STAGES-1];
        end
    end

    logic rd_pre, sh_pre, din_pre;
    assign {rd_pre, sh_pre, din_pre} = ctl_pre;

    logic [ID_WIDTH-1:0] sr;
    dna_state_e          state;
    logic [CNT_W-1:0]    cnt_inc;

    assign cnt_inc = sat_inc(shift_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            dna_dout  <= 1'b0;
            loaded    <= 1'b0;
            shift_cnt <= '0;
            shift_err <= 1'b0;
            state     <= ST_EMPTY;
        end else begin
            dna_dout <= sr[ID_WIDTH-1];
            if (clk_rise) begin
                if (rd_pre) begin
                    sr        <= ID_VALUE;
                    shift_cnt <= '0;
                    loaded    <= 1'b1;
                    state     <= ST_LOADED;
                end else if (sh_pre) begin
                    sr        <= {sr[ID_WIDTH-2:0], din_pre};
                    shift_cnt <= cnt_inc;
                    case (state)
                        ST_EMPTY:    shift_err <= 1'b1;
                        ST_LOADED:   state <= (cnt_inc >= ID_CNT) ? ST_DONE : ST_SHIFTING;
                        ST_SHIFTING: if (cnt_inc >= ID_CNT) state <= ST_DONE;
                        default:     state <= ST_DONE;
                    endcase
                end
            end
        end
    end

    assign done = (shift_cnt >= ID_CNT);

endmodule
